// File: rtl/recon_frame_tx_pkg.sv
// rtl/recon_frame_tx_pkg.sv - shared constants, recon header layout and FSM states
// Contents: header byte counts, func_type codes, recon_hdr_t (64b, LE on the wire),
// and the framer state enum.
package recon_frame_tx_pkg;

    localparam int ETH_HDR_BYTES   = 46;
    localparam int RECON_HDR_BYTES = 8;
    localparam int HDR_BYTES       = ETH_HDR_BYTES + RECON_HDR_BYTES;

    typedef enum logic [1:0] {
        FUNC_BITSTREAM = 2'b00,
        FUNC_RSVD_1    = 2'b01,
        FUNC_RSVD_2    = 2'b10,
        FUNC_RSVD_3    = 2'b11
    } func_type_t;

    // Declared MSB first so that func_type lands in bits [1:0].
    typedef struct packed {
        logic [31:0] size;
        logic        size_valid;
        logic [20:0] seq;
        logic [7:0]  id;
        func_type_t  func_type;
    } recon_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_FLUSH,
        ST_FLUSH_END
    } state_t;

endpackage

// File: rtl/recon_frame_tx_if.sv
// rtl/recon_frame_tx_if.sv - byte-lane stream bundle used for payload input and framed output
// Signals: tdata, tkeep (lane enables, contiguous from lane 0), tvalid, tlast, tready.
// Modports: master drives data/valid/last, slave drives ready.
interface recon_frame_tx_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/recon_frame_tx_hdr_pack.sv
// rtl/recon_frame_tx_hdr_pack.sv - combinational packer for the 64b recon header
// Inputs: hdr_id[7:0], hdr_size[31:0], hdr_seq[20:0], hdr_size_valid.
// Output: hdr (recon_hdr_t), func_type fixed to bitstream transfer.
module recon_hdr_pack
    import recon_frame_tx_pkg::*;
(
    input  logic [7:0]  hdr_id,
    input  logic [31:0] hdr_size,
    input  logic [20:0] hdr_seq,
    input  logic        hdr_size_valid,
    output recon_hdr_t  hdr
);

    assign hdr = '{size:       hdr_size,
                   size_valid: hdr_size_valid,
                   seq:        hdr_seq,
                   id:         hdr_id,
                   func_type:  FUNC_BITSTREAM};

endmodule

// File: rtl/recon_frame_tx.sv
// rtl/recon_frame_tx.sv - segments a bitstream payload stream into Eth/IP/RMT + recon framed packets
// Ports: s_axis_clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_id/cmd_size start a transfer;
// cfg_eth_hdr (368b, byte 0 in [7:0]) sampled at command accept; s_axis payload in; m_axis framed out;
// stat_frames counts sent frames (wraps); err_size pulses on a size mismatch.
// Optional: RECON_TX_SIZE_CHECK_EN enables the accepted-byte counter driving err_size.
module recon_frame_tx
    import recon_frame_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int FRAME_BEATS = 16
) (
    input  logic                       s_axis_clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [7:0]                 cmd_id,
    input  logic [31:0]                cmd_size,
    input  logic [ETH_HDR_BYTES*8-1:0] cfg_eth_hdr,
    recon_frame_tx_if.slave            s_axis,
    recon_frame_tx_if.master           m_axis,
    output logic [15:0]                stat_frames,
    output logic                       err_size
);

    // Payload bytes that fit behind the headers in a frame's first beat.
    localparam int S_BYTES = KEEP_WIDTH - HDR_BYTES;
    localparam int CNT_W   = $clog2(KEEP_WIDTH) + 1;
    localparam int RES_W   = HDR_BYTES * 8;
    localparam int BEAT_W  = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

    function automatic logic [CNT_W-1:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            n = n + CNT_W'(k[i]);
        end
        return n;
    endfunction

    function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [CNT_W-1:0] n);
        logic [KEEP_WIDTH-1:0] m;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            m[i] = (CNT_W'(i) < n);
        end
        return m;
    endfunction

    state_t                     state;
    logic [7:0]                 id_q;
    logic [31:0]                size_q;
    logic [ETH_HDR_BYTES*8-1:0] eth_q;
    logic [20:0]                seq_q;
    logic [BEAT_W-1:0]          beat_cnt;
    logic [RES_W-1:0]           residue;
    logic [CNT_W-1:0]           res_cnt;

    logic [DATA_WIDTH-1:0]      m_tdata_q;
    logic [KEEP_WIDTH-1:0]      m_tkeep_q;
    logic                       m_tvalid_q;
    logic                       m_tlast_q;

    recon_hdr_t                 recon_hdr;
    logic                       load_en;
    logic                       in_fire;
    logic [CNT_W-1:0]           in_cnt;
    logic                       in_short;

    recon_hdr_pack u_hdr_pack (
        .hdr_id         (id_q),
        .hdr_size       (size_q),
        .hdr_seq        (seq_q),
        .hdr_size_valid (seq_q == 21'd0),
        .hdr            (recon_hdr)
    );

    assign load_en       = !m_tvalid_q || m_axis.tready;
    assign s_axis.tready = load_en && (state == ST_HDR || state == ST_PAYLOAD);
    assign in_fire       = s_axis.tvalid && s_axis.tready;
    assign in_cnt        = popcount(s_axis.tkeep);
    // A final beat this short fits entirely in the current output beat, so no residue beat follows.
    assign in_short      = (in_cnt <= CNT_W'(S_BYTES));

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tkeep  = m_tkeep_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;

    always_ff @(posedge s_axis_clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b0;
            id_q       <= '0;
            size_q     <= '0;
            eth_q      <= '0;
            seq_q      <= '0;
            beat_cnt   <= '0;
            residue    <= '0;
            res_cnt    <= '0;
            m_tdata_q  <= '0;
            m_tkeep_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else begin
            // Output slot drains unless a new beat is loaded below.
            if (load_en) begin
                m_tvalid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        id_q      <= cmd_id;
                        size_q    <= cmd_size;
                        eth_q     <= cfg_eth_hdr;
                        seq_q     <= '0;
                        state     <= ST_HDR;
                    end
                end

                ST_HDR, ST_PAYLOAD: begin
                    if (in_fire) begin
                        if (state == ST_HDR) begin
                            m_tdata_q <= {s_axis.tdata[S_BYTES*8-1:0], recon_hdr, eth_q};
                            beat_cnt  <= BEAT_W'(1);
                        end else begin
                            m_tdata_q <= {s_axis.tdata[S_BYTES*8-1:0], residue};
                            beat_cnt  <= beat_cnt + BEAT_W'(1);
                        end
                        m_tvalid_q <= 1'b1;
                        residue    <= s_axis.tdata[DATA_WIDTH-1:S_BYTES*8];

                        if (s_axis.tlast && in_short) begin
                            m_tkeep_q <= keep_mask(CNT_W'(HDR_BYTES) + in_cnt);
                            m_tlast_q <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            m_tkeep_q <= '1;
                            m_tlast_q <= 1'b0;
                            res_cnt   <= in_cnt - CNT_W'(S_BYTES);
                            if (s_axis.tlast) begin
                                state <= ST_FLUSH_END;
                            end else if (state == ST_HDR) begin
                                state <= (FRAME_BEATS == 1) ? ST_FLUSH : ST_PAYLOAD;
                            end else if (beat_cnt == BEAT_W'(FRAME_BEATS - 1)) begin
                                state <= ST_FLUSH;
                            end
                        end
                    end
                end

                ST_FLUSH, ST_FLUSH_END: begin
                    if (load_en) begin
                        m_tdata_q  <= {{(S_BYTES*8){1'b0}}, residue};
                        m_tkeep_q  <= keep_mask(res_cnt);
                        m_tlast_q  <= 1'b1;
                        m_tvalid_q <= 1'b1;
                        if (state == ST_FLUSH) begin
                            seq_q <= seq_q + 21'd1;
                            state <= ST_HDR;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axis_clk) begin
        if (rst) begin
            stat_frames <= '0;
        end else if (m_tvalid_q && m_axis.tready && m_tlast_q) begin
            stat_frames <= stat_frames + 16'd1;
        end
    end

`ifdef RECON_TX_SIZE_CHECK_EN
    logic [31:0] byte_cnt;
    logic        err_q;

    always_ff @(posedge s_axis_clk) begin
        if (rst) begin
            byte_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == ST_IDLE && cmd_valid && cmd_ready) begin
                byte_cnt <= '0;
            end else if (in_fire) begin
                if (s_axis.tlast) begin
                    byte_cnt <= '0;
                    err_q    <= ((byte_cnt + 32'(in_cnt)) != size_q);
                end else begin
                    byte_cnt <= byte_cnt + 32'(in_cnt);
                end
            end
        end
    end

    assign err_size = err_q;
`else
    assign err_size = 1'b0;
`endif

endmodule
